mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM pipeline stage of the 5-stage CPU, between the EX/MEM register and the MEM/WB register.
//  Issues loads/stores on the SRAM-like data bus (req/addr_ok/data_ok) via a small FSM, stalling the pipe until done.
//  Extends load data, generates store strobes, flags misaligned accesses; passes non-memory results through.
// PARAMETERS
//  ADDR_W   32  data bus / effective address width
//  DATA_W   32  register and data bus width (`RegBus)
// PORTS
//  clk           in   1   clock, all state updates on rising edge
//  rst           in   1   synchronous reset, active-low (0 = reset)
//  waddr_i       in   5   dest reg addr from EX/MEM
//  wdata_i       in   32  ALU result from EX/MEM
//  we_i          in   1   dest reg write enable from EX/MEM
//  mem_op_i      in   4   NONE/LB/LBU/LH/LHU/LW/SB/SH/SW
//  mem_addr_i    in   32  effective address
//  mem_sdata_i   in   32  store data (rt)
//  waddr_o       out  5   to MEM/WB
//  wdata_o       out  32  to MEM/WB: ALU result, or extended load data
//  we_o          out  1   to MEM/WB
//  stallreq_o    out  1   to pipeline control: hold IF..MEM, bubble into MEM/WB
//  exc_adel_o    out  1   misaligned load
//  exc_ades_o    out  1   misaligned store
//  data_req      out  1   bus request
//  data_wr       out  1   1 = store
//  data_size     out  2   0 byte, 1 half, 2 word
//  data_addr     out  32  = mem_addr_i, unmasked
//  data_wstrb    out  4   byte strobes (stores only, else 0)
//  data_wdata    out  32  store data replicated across lanes
//  data_addr_ok  in   1   request accepted this cycle
//  data_data_ok  in   1   read data valid / write done this cycle
//  data_rdata    in   32  read data
// BEHAVIOUR
//  - Reset (rst=0 at edge): state<=IDLE, rdata_q<=0. Outputs are forced low while rst=0:
//    data_req, stallreq_o, we_o, exc_*; waddr_o=`NOPRegAddr, wdata_o=`ZeroWord.
//  - Reset mid-transaction abandons it; the bus slave shares rst.
//  - Access = mem_op_i!=NONE and aligned. Alignment rule: H ops need addr[0]=0; W ops need addr[1:0]=0.
//  - Misaligned: no request, no stall. exc_adel_o (loads) or exc_ades_o (stores)=1, we_o=0, same cycle.
//  - Non-memory op: waddr/wdata/we pass through combinationally, stallreq_o=0.
//  - FSM states IDLE, REQ, WAIT, DONE:
//     IDLE: on access, data_req=1 and stallreq_o=1 combinationally.
//           If addr_ok -> WAIT, else -> REQ.
//     REQ:  data_req=1, stallreq_o=1; addr_ok -> WAIT.
//     WAIT: data_req=0, stallreq_o=1; data_ok -> DONE, capturing rdata_q<=data_rdata (loads).
//     DONE: data_req=0, stallreq_o=0. Outputs are valid for MEM/WB. -> IDLE unconditionally.
//  - Inputs are held stable by the stall from IDLE through DONE. DONE never re-issues a request.
//  - addr_ok and data_ok in the same cycle in REQ: ignore data_ok, go WAIT. Slave contract: data_ok is at least 1 cycle after addr_ok.
//  - Min latency: addr_ok in cycle 0, data_ok in cycle 1, DONE in cycle 2; stallreq high for 2 cycles.
//  - we_o for a memory op is 0 until DONE. In DONE: loads use we_i; stores always give we_o=0.
//  - Load extend (o=addr[1:0]):
//     LB/LBU: rdata_q[8*o+:8], sign/zero extended.
//     LH/LHU: rdata_q[16*o[1]+:16], sign/zero extended.
//     LW: rdata_q.
//  - Store: SB wstrb=4'b0001<<o, wdata={4{sdata[7:0]}}. SH wstrb=o[1]?1100:0011, wdata={2{sdata[15:0]}}. SW wstrb=1111.
//  - data_wr, data_size, data_wstrb and data_wdata are driven from the inputs in every state; they matter only while data_req=1.
// STRUCTURE
//  - Defines.v holds: mem_op codes and `MemOpBus [3:0], FSM state codes, `NOPRegAddr, `ZeroWord, `RstEnable (=1'b0).
//  - One combinational sub-module, mem_align, holds the alignment check, strobe/size/wdata generation and load extension.
//  - FSM and rdata_q live in mem_access_stage.
// TESTING
//  1 ALU op waddr=5'd3 wdata=32'h1234 we=1 -> same-cycle passthrough; stallreq_o=0, data_req=0.
//  2 LB addr=32'h1002, rdata=32'h0080_0000; addr_ok cycle 0, data_ok cycle 1 -> DONE in cycle 2, wdata_o=32'hFFFF_FF80, stall for 2 cycles.
//  3 LHU addr=32'h2002, addr_ok held off 3 cycles, rdata=32'h8001_0000 -> REQ for 3 cycles, then wdata_o=32'h0000_8001.
//  4 SB addr=32'h3003, sdata=32'hAB -> data_wr=1, size=0, wstrb=4'b1000, wdata=32'hABAB_ABAB; we_o=0 in DONE.
//  5 LW addr=32'h4002 -> exc_adel_o=1, no data_req, we_o=0, no stall. SH addr=32'h4001 -> exc_ades_o=1.
//  6 rst=0 asserted while in WAIT -> next cycle IDLE. data_req, stallreq_o and we_o=0. A later data_ok is ignored.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: memory op codes,
// bus-transaction FSM states and pipeline idle values.
package mem_access_stage_pkg;

  typedef enum logic [3:0] {
    MemNone = 4'd0,
    MemLb   = 4'd1,
    MemLbu  = 4'd2,
    MemLh   = 4'd3,
    MemLhu  = 4'd4,
    MemLw   = 4'd5,
    MemSb   = 4'd6,
    MemSh   = 4'd7,
    MemSw   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam logic [4:0]  NopRegAddr = 5'd0;
  localparam logic [31:0] ZeroWord   = 32'd0;
  localparam logic        RstEnable  = 1'b0;

  localparam logic [1:0] SizeByte = 2'd0;
  localparam logic [1:0] SizeHalf = 2'd1;
  localparam logic [1:0] SizeWord = 2'd2;

endpackage

// File: rtl/mem_align.sv
// Combinational helper for the MEM stage: op decode, alignment check,
// store size/strobe/lane replication and load-data extension.
module mem_align
  import mem_access_stage_pkg::*;
(
  input  logic [3:0]  mem_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic        is_load,
  output logic        is_store,
  output logic        misaligned,
  output logic [1:0]  size,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    misaligned = 1'b0;
    size       = SizeWord;
    wstrb      = 4'b0000;
    wdata      = sdata;
    load_data  = rdata;
    case (mem_op)
      MemLb: begin
        is_load   = 1'b1;
        size      = SizeByte;
        load_data = {{24{byte_sel[7]}}, byte_sel};
      end
      MemLbu: begin
        is_load   = 1'b1;
        size      = SizeByte;
        load_data = {24'd0, byte_sel};
      end
      MemLh: begin
        is_load    = 1'b1;
        size       = SizeHalf;
        misaligned = addr_lo[0];
        load_data  = {{16{half_sel[15]}}, half_sel};
      end
      MemLhu: begin
        is_load    = 1'b1;
        size       = SizeHalf;
        misaligned = addr_lo[0];
        load_data  = {16'd0, half_sel};
      end
      MemLw: begin
        is_load    = 1'b1;
        misaligned = |addr_lo;
      end
      MemSb: begin
        is_store = 1'b1;
        size     = SizeByte;
        wstrb    = 4'b0001 << addr_lo;
        wdata    = {4{sdata[7:0]}};
      end
      MemSh: begin
        is_store   = 1'b1;
        size       = SizeHalf;
        misaligned = addr_lo[0];
        wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{sdata[15:0]}};
      end
      MemSw: begin
        is_store   = 1'b1;
        misaligned = |addr_lo;
        wstrb      = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives loads/stores over the req/addr_ok/data_ok data bus,
// stalling the pipe until the access completes, else passes ALU results through.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              we_i,
  input  logic [3:0]        mem_op_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_sdata_i,
  output logic [4:0]        waddr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              we_o,
  output logic              stallreq_o,
  output logic              exc_adel_o,
  output logic              exc_ades_o,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] rdata_q;

  logic              is_load, is_store, misaligned, access;
  logic [3:0]        strb;
  logic [DATA_W-1:0] load_data;

  mem_align u_align (
    .mem_op     (mem_op_i),
    .addr_lo    (mem_addr_i[1:0]),
    .sdata      (mem_sdata_i),
    .rdata      (rdata_q),
    .is_load    (is_load),
    .is_store   (is_store),
    .misaligned (misaligned),
    .size       (data_size),
    .wstrb      (strb),
    .wdata      (data_wdata),
    .load_data  (load_data)
  );

  assign access     = (is_load | is_store) & ~misaligned;
  assign data_addr  = mem_addr_i;
  assign data_wr    = is_store;
  assign data_wstrb = is_store ? strb : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= StIdle;
      rdata_q <= ZeroWord;
    end else begin
      state_q <= state_d;
      if (state_q == StWait && data_data_ok && is_load) begin
        rdata_q <= data_rdata;
      end
    end
  end

  always_comb begin
    state_d    = StIdle;
    data_req   = 1'b0;
    stallreq_o = 1'b0;
    waddr_o    = waddr_i;
    wdata_o    = wdata_i;
    we_o       = we_i & ~misaligned;
    exc_adel_o = is_load & misaligned;
    exc_ades_o = is_store & misaligned;
    if (access) begin
      we_o = 1'b0;
      unique case (state_q)
        StIdle, StReq: begin
          data_req   = 1'b1;
          stallreq_o = 1'b1;
          state_d    = data_addr_ok ? StWait : StReq;
        end
        StWait: begin
          stallreq_o = 1'b1;
          state_d    = data_data_ok ? StDone : StWait;
        end
        StDone: begin
          // Stores never write back; loads take the extended bus data.
          if (is_load) begin
            we_o    = we_i;
            wdata_o = load_data;
          end
        end
      endcase
    end
    if (rst == RstEnable) begin
      data_req   = 1'b0;
      stallreq_o = 1'b0;
      we_o       = 1'b0;
      exc_adel_o = 1'b0;
      exc_ades_o = 1'b0;
      waddr_o    = NopRegAddr;
      wdata_o    = ZeroWord;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: flag-based transaction model checked
// every cycle, plus directed transactions with hand-computed results.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic        we_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_sdata_i;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        we_o, stallreq_o, exc_adel_o, exc_ades_o;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  mem_access_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .waddr_i      (waddr_i),
    .wdata_i      (wdata_i),
    .we_i         (we_i),
    .mem_op_i     (mem_op_i),
    .mem_addr_i   (mem_addr_i),
    .mem_sdata_i  (mem_sdata_i),
    .waddr_o      (waddr_o),
    .wdata_o      (wdata_o),
    .we_o         (we_o),
    .stallreq_o   (stallreq_o),
    .exc_adel_o   (exc_adel_o),
    .exc_ades_o   (exc_ades_o),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_is_ld(input logic [3:0] op);
    return op == MemLb || op == MemLbu || op == MemLh || op == MemLhu || op == MemLw;
  endfunction

  function automatic bit m_is_st(input logic [3:0] op);
    return op == MemSb || op == MemSh || op == MemSw;
  endfunction

  function automatic bit m_mis(input logic [3:0] op, input logic [31:0] a);
    if (op == MemLh || op == MemLhu || op == MemSh) return a[0];
    if (op == MemLw || op == MemSw) return a[1:0] != 2'd0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_ext(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] r);
    logic [31:0] b, h;
    b = (r >> (8 * a[1:0])) & 32'hFF;
    h = (r >> (a[1] ? 16 : 0)) & 32'hFFFF;
    case (op)
      MemLb:   return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      MemLbu:  return b;
      MemLh:   return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      MemLhu:  return h;
      default: return r;
    endcase
  endfunction

  function automatic logic [1:0] m_size(input logic [3:0] op);
    if (op == MemLb || op == MemLbu || op == MemSb) return 2'd0;
    if (op == MemLh || op == MemLhu || op == MemSh) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [3:0] m_strb(input logic [3:0] op, input logic [31:0] a);
    if (op == MemSb) return 4'(32'd1 << a[1:0]);
    if (op == MemSh) return a[1] ? 4'hC : 4'h3;
    if (op == MemSw) return 4'hF;
    return 4'h0;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] s);
    if (op == MemSb) return {24'd0, s[7:0]} * 32'h0101_0101;
    if (op == MemSh) return {16'd0, s[15:0]} * 32'h0001_0001;
    return s;
  endfunction

  // Model: has the address been accepted, and is the result being presented now.
  bit          m_acc = 1'b0;
  bit          m_done = 1'b0;
  logic [31:0] m_rdata = 32'd0;

  always @(posedge clk) begin
    if (rst !== 1'b1) begin
      m_acc  <= 1'b0;
      m_done <= 1'b0;
      m_rdata <= 32'd0;
    end else if ((m_is_ld(mem_op_i) || m_is_st(mem_op_i)) && !m_mis(mem_op_i, mem_addr_i)) begin
      if (m_done) begin
        m_done <= 1'b0;
      end else if (!m_acc) begin
        if (data_addr_ok) m_acc <= 1'b1;
      end else if (data_data_ok) begin
        m_acc  <= 1'b0;
        m_done <= 1'b1;
        if (m_is_ld(mem_op_i)) m_rdata <= data_rdata;
      end
    end else begin
      m_acc  <= 1'b0;
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic        ld, st, mis, e_req, e_stall, e_we, e_adel, e_ades, wd_ok;
      logic [4:0]  e_waddr;
      logic [31:0] e_wdata;
      ld = m_is_ld(mem_op_i);
      st = m_is_st(mem_op_i);
      mis = m_mis(mem_op_i, mem_addr_i);
      e_req = 1'b0; e_stall = 1'b0; e_we = we_i; e_adel = ld & mis; e_ades = st & mis;
      e_waddr = waddr_i; e_wdata = wdata_i; wd_ok = 1'b1;
      if (rst !== 1'b1) begin
        e_we = 1'b0; e_adel = 1'b0; e_ades = 1'b0; e_waddr = 5'd0; e_wdata = 32'd0;
      end else if (mis) begin
        e_we = 1'b0; wd_ok = 1'b0;
      end else if (ld || st) begin
        if (m_done) begin
          e_we = ld ? we_i : 1'b0;
          e_wdata = m_ext(mem_op_i, mem_addr_i, m_rdata);
          wd_ok = ld;
        end else begin
          e_we = 1'b0; wd_ok = 1'b0; e_stall = 1'b1; e_req = !m_acc;
        end
      end
      chk("m_stallreq", 32'(stallreq_o), 32'(e_stall));
      chk("m_data_req", 32'(data_req), 32'(e_req));
      chk("m_we", 32'(we_o), 32'(e_we));
      chk("m_adel", 32'(exc_adel_o), 32'(e_adel));
      chk("m_ades", 32'(exc_ades_o), 32'(e_ades));
      chk("m_waddr", 32'(waddr_o), 32'(e_waddr));
      if (wd_ok) chk("m_wdata", wdata_o, e_wdata);
      if (e_req) begin
        chk("m_bus_addr", data_addr, mem_addr_i);
        chk("m_bus_wr", 32'(data_wr), 32'(st));
        chk("m_bus_size", 32'(data_size), 32'(m_size(mem_op_i)));
        chk("m_bus_wstrb", 32'(data_wstrb), 32'(m_strb(mem_op_i, mem_addr_i)));
        if (st) chk("m_bus_wdata", data_wdata, m_wdata(mem_op_i, mem_sdata_i));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [31:0] t_wdata, t0_bwdata;
  logic        t_we, t0_wr;
  logic [3:0]  t0_wstrb;
  logic [1:0]  t0_size;
  int          t_stall, t_req;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rdata, input int a_dly, input int d_dly);
    mem_op_i = op; mem_addr_i = addr; mem_sdata_i = sdata; data_rdata = rdata;
    waddr_i = 5'd9; wdata_i = 32'h5555_0000; we_i = 1'b1;
    t_stall = 0; t_req = 0;
    for (int i = 0; i <= a_dly; i++) begin
      data_addr_ok = (i == a_dly);
      @(negedge clk);
      if (i == 0) begin
        t0_wstrb = data_wstrb; t0_bwdata = data_wdata; t0_wr = data_wr; t0_size = data_size;
      end
      t_stall += int'(stallreq_o); t_req += int'(data_req);
      tick();
    end
    data_addr_ok = 1'b0;
    for (int i = 0; i <= d_dly; i++) begin
      data_data_ok = (i == d_dly);
      @(negedge clk);
      t_stall += int'(stallreq_o); t_req += int'(data_req);
      tick();
    end
    data_data_ok = 1'b0;
    @(negedge clk);
    t_wdata = wdata_o; t_we = we_o; t_stall += int'(stallreq_o); t_req += int'(data_req);
    tick();
    mem_op_i = MemNone;
  endtask

  initial begin
    rst = 1'b0; waddr_i = 5'd7; wdata_i = 32'hDEAD_BEEF; we_i = 1'b1;
    mem_op_i = MemLw; mem_addr_i = 32'h0; mem_sdata_i = 32'h0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_req", 32'(data_req), 32'd0);
    chk("rst_stall", 32'(stallreq_o), 32'd0);
    chk("rst_we", 32'(we_o), 32'd0);
    chk("rst_waddr", 32'(waddr_o), 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);
    tick();
    rst = 1'b1; mem_op_i = MemNone;

    // ALU passthrough
    waddr_i = 5'd3; wdata_i = 32'h1234; we_i = 1'b1;
    @(negedge clk);
    chk("alu_wdata", wdata_o, 32'h1234);
    chk("alu_waddr", 32'(waddr_o), 32'd3);
    chk("alu_we", 32'(we_o), 32'd1);
    chk("alu_stall", 32'(stallreq_o), 32'd0);
    chk("alu_req", 32'(data_req), 32'd0);
    tick();

    run_txn(MemLb, 32'h1002, 32'h0, 32'h0080_0000, 0, 0);
    chk("lb_wdata", t_wdata, 32'hFFFF_FF80);
    chk("lb_we", 32'(t_we), 32'd1);
    chk("lb_stall_cycles", 32'(t_stall), 32'd2);

    run_txn(MemLhu, 32'h2002, 32'h0, 32'h8001_0000, 3, 0);
    chk("lhu_wdata", t_wdata, 32'h0000_8001);
    chk("lhu_req_cycles", 32'(t_req), 32'd4);
    chk("lhu_stall_cycles", 32'(t_stall), 32'd5);

    run_txn(MemSb, 32'h3003, 32'h0000_00AB, 32'h0, 0, 1);
    chk("sb_wr", 32'(t0_wr), 32'd1);
    chk("sb_size", 32'(t0_size), 32'd0);
    chk("sb_wstrb", 32'(t0_wstrb), 32'b1000);
    chk("sb_bwdata", t0_bwdata, 32'hABAB_ABAB);
    chk("sb_we_done", 32'(t_we), 32'd0);

    run_txn(MemLh, 32'h0000, 32'h0, 32'h0000_8123, 1, 2);
    chk("lh_wdata", t_wdata, 32'hFFFF_8123);
    run_txn(MemLbu, 32'h1001, 32'h0, 32'h0000_F000, 0, 0);
    chk("lbu_wdata", t_wdata, 32'h0000_00F0);
    run_txn(MemLb, 32'h1003, 32'h0, 32'h7F00_0000, 0, 0);
    chk("lb_pos_wdata", t_wdata, 32'h0000_007F);
    run_txn(MemSh, 32'h2002, 32'h1234_5678, 32'h0, 0, 0);
    chk("sh_wstrb", 32'(t0_wstrb), 32'b1100);
    chk("sh_bwdata", t0_bwdata, 32'h5678_5678);
    run_txn(MemSw, 32'h0, 32'hCAFE_0001, 32'h0, 2, 0);
    chk("sw_wstrb", 32'(t0_wstrb), 32'b1111);

    // Misaligned accesses
    mem_op_i = MemLw; mem_addr_i = 32'h4002; we_i = 1'b1;
    @(negedge clk);
    chk("lw_mis_adel", 32'(exc_adel_o), 32'd1);
    chk("lw_mis_req", 32'(data_req), 32'd0);
    chk("lw_mis_stall", 32'(stallreq_o), 32'd0);
    chk("lw_mis_we", 32'(we_o), 32'd0);
    tick();
    mem_op_i = MemSh; mem_addr_i = 32'h4001;
    @(negedge clk);
    chk("sh_mis_ades", 32'(exc_ades_o), 32'd1);
    chk("sh_mis_adel", 32'(exc_adel_o), 32'd0);
    tick();

    // Reset while waiting for data
    mem_op_i = MemLw; mem_addr_i = 32'h5000; we_i = 1'b1; data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("rstw_req", 32'(data_req), 32'd0);
    chk("rstw_stall", 32'(stallreq_o), 32'd0);
    chk("rstw_we", 32'(we_o), 32'd0);
    tick();
    rst = 1'b1; mem_op_i = MemNone; data_data_ok = 1'b1; data_rdata = 32'h1111_2222;
    @(negedge clk);
    chk("late_dok_stall", 32'(stallreq_o), 32'd0);
    tick();
    data_data_ok = 1'b0; mem_op_i = MemLw; mem_addr_i = 32'h5000;
    @(negedge clk);
    chk("after_rst_req", 32'(data_req), 32'd1);
    chk("after_rst_stall", 32'(stallreq_o), 32'd1);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
    tick();
    data_data_ok = 1'b0;
    @(negedge clk);
    chk("after_rst_wdata", wdata_o, 32'hCAFE_F00D);
    chk("after_rst_we", 32'(we_o), 32'd1);
    tick();
    mem_op_i = MemNone;
    tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
